// File: rtl/axis_fan_in_if.sv
// axis_fan_in_if: bundle of the source-side and master-side AXI-stream
// signals of the fan-in arbiter.
//   s_axis_tvalid/tdata/tlast  NUM_FANIN source streams into the arbiter
//   s_axis_tready              per-source ready, at most one bit high
//   m_axis_tvalid/tdata/tlast  merged output stream
//   m_axis_tuser               one-hot source id of the current beat
//   m_axis_tready              downstream ready
// Modports:
//   slave  - the arbiter's view (consumes the source streams, drives m_axis)
//   master - the environment's view (drives the sources, consumes m_axis)
interface axis_fan_in_if #(
  parameter int NUM_FANIN  = 6,
  parameter int DATA_WIDTH = 256
);
  logic [NUM_FANIN-1:0]            s_axis_tvalid;
  logic [NUM_FANIN-1:0]            s_axis_tready;
  logic [NUM_FANIN*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_FANIN-1:0]            s_axis_tlast;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [NUM_FANIN-1:0]            m_axis_tuser;
  logic                            m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/axis_fan_in.sv
// axis_fan_in: round-robin, packet-locked AXI-stream arbiter merging
// NUM_FANIN source streams into one registered master stream.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  axis_fan_in_if.slave: source streams in, merged stream out with a
//        one-hot tuser naming the source of each beat
// A grant is held from the first beat through tlast; the next search starts
// one index above the source that finished last.
module axis_fan_in #(
  parameter int NUM_FANIN  = 6,
  parameter int DATA_WIDTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  axis_fan_in_if.slave bus
);
  localparam int IDX_W = (NUM_FANIN > 1) ? $clog2(NUM_FANIN) : 1;
  localparam logic [NUM_FANIN-1:0] ONE = NUM_FANIN'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q;
  logic [NUM_FANIN-1:0]   grant_q;
  logic [NUM_FANIN-1:0]   grant_d;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_hit;
  int                     cand;

  logic [NUM_FANIN-1:0]   s_ready;
  logic                   out_free;
  logic                   xfer;
  logic                   xfer_last;
  logic [DATA_WIDTH-1:0]  data_p0;

  logic                   vld_p1_q;
  logic [DATA_WIDTH-1:0]  data_p1_q;
  logic [NUM_FANIN-1:0]   user_p1_q;
  logic                   last_p1_q;

  // Round-robin search upward from last_q+1 with wrap.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_FANIN; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_FANIN) begin
        cand = cand - NUM_FANIN;
      end
      if (!sel_hit && bus.s_axis_tvalid[cand]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end

  assign grant_d = ONE << sel_idx;

  // The output slot is free when empty or draining this cycle; this is the
  // only combinational input to s_axis_tready.
  assign out_free  = ~vld_p1_q | bus.m_axis_tready;
  assign s_ready   = (state_q == LOCKED && out_free) ? grant_q : '0;
  assign xfer      = |(bus.s_axis_tvalid & s_ready);
  assign xfer_last = |(bus.s_axis_tlast & grant_q);
  assign data_p0   = bus.s_axis_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

  assign bus.s_axis_tready = s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NUM_FANIN - 1);
      vld_p1_q  <= 1'b0;
      user_p1_q <= '0;
      last_p1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_hit) begin
            grant_q <= grant_d;
            gidx_q  <= sel_idx;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && xfer_last) begin
            grant_q <= '0;
            last_q  <= gidx_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // ---- stage p0 -> p1: output register control ----
      if (xfer) begin
        vld_p1_q  <= 1'b1;
        user_p1_q <= grant_q;
        last_p1_q <= xfer_last;
      end else if (bus.m_axis_tready) begin
        vld_p1_q  <= 1'b0;
      end
    end
  end

  // Data needs no reset: it is only visible while vld_p1_q is set.
  always_ff @(posedge clk) begin
    if (xfer) begin
      data_p1_q <= data_p0;
    end
  end

  // ---- stage p1: master outputs, zeroed while not valid ----
  assign bus.m_axis_tvalid = vld_p1_q;
  assign bus.m_axis_tdata  = vld_p1_q ? data_p1_q : '0;
  assign bus.m_axis_tuser  = vld_p1_q ? user_p1_q : '0;
  assign bus.m_axis_tlast  = vld_p1_q & last_p1_q;
endmodule

// File: tb/tb_axis_fan_in.sv
// tb_axis_fan_in: directed scenarios plus a randomized phase for axis_fan_in.
// Source drivers pop per-source beat queues on accepted transfers; a monitor
// records every master beat. Expected streams come from packet-level rules.
module tb_axis_fan_in;
  localparam int NF = 6;
  localparam int DW = 256;

  typedef struct { logic [DW-1:0] data; logic last; logic first; } beat_t;
  typedef struct { logic [DW-1:0] data; logic [NF-1:0] user; logic last; int cyc; } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_fan_in_if #(.NUM_FANIN(NF), .DATA_WIDTH(DW)) bus ();
  axis_fan_in #(.NUM_FANIN(NF), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  beat_t         srcq [NF][$];
  obs_t          capq [$];
  obs_t          expq [$];
  int            plen [NF][$];
  logic [DW-1:0] pdat [NF][$];

  int            npass = 0;
  int            ntotal = 0;
  int            cyc = 0;
  int            nstall = 0;
  int            rmode = 0;
  bit            rand_hold = 1'b0;
  logic [NF-1:0] hold = '0;
  logic [NF-1:0] rdy_s;
  int            xfer_src = -1;
  bit            xfer_last = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [NF:0]   prev_ul;
  int            k, g, tl;
  bit            saw0;

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mk(int s, int p, int b);
    return DW'(49152 + s*256 + p*16 + b);
  endfunction

  task automatic load_pkt(int s, int p, int n);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x.data  = mk(s, p, b);
      x.last  = (b == n-1);
      x.first = (b == 0);
      srcq[s].push_back(x);
    end
  endtask

  task automatic exp_beat(logic [DW-1:0] d, int s, bit l);
    obs_t o;
    o.data = d;
    o.user = NF'(1) << s;
    o.last = l;
    o.cyc  = 0;
    expq.push_back(o);
  endtask

  task automatic exp_pkt(int s, int p, int n);
    for (int b = 0; b < n; b++) exp_beat(mk(s, p, b), s, b == n-1);
  endtask

  task automatic drive();
    for (int i = 0; i < NF; i++) begin
      if (rand_hold) hold[i] = (srcq[i].size() > 0 && !srcq[i][0].first) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (srcq[i].size() > 0) begin
        bus.s_axis_tvalid[i]          = !hold[i];
        bus.s_axis_tdata[i*DW +: DW]  = srcq[i][0].data;
        bus.s_axis_tlast[i]           = srcq[i][0].last;
      end else begin
        bus.s_axis_tvalid[i]          = 1'b0;
        bus.s_axis_tdata[i*DW +: DW]  = '0;
        bus.s_axis_tlast[i]           = 1'b0;
      end
    end
    case (rmode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = (cyc % 3 == 0);
      default: bus.m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: sample at the falling edge, update drivers 1ns after rising.
  task automatic cycle();
    obs_t o;
    @(negedge clk);
    rdy_s = bus.s_axis_tready;
    if (!rst) begin
      chk("ready_onehot0", DW'($onehot0(rdy_s)), DW'(1));
      if (!bus.m_axis_tvalid) begin
        chk("idle_data_zero", bus.m_axis_tdata, '0);
        chk("idle_user_last_zero", DW'({bus.m_axis_tuser, bus.m_axis_tlast}), '0);
      end
      if (prev_stall) begin
        chk("stall_valid_held", DW'(bus.m_axis_tvalid), DW'(1));
        chk("stall_data_stable", bus.m_axis_tdata, prev_d);
        chk("stall_user_last_stable", DW'({bus.m_axis_tuser, bus.m_axis_tlast}), DW'(prev_ul));
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
        nstall++;
        chk("stall_src_ready_low", DW'(rdy_s), '0);
      end
    end
    prev_stall = !rst && bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_d     = bus.m_axis_tdata;
    prev_ul    = {bus.m_axis_tuser, bus.m_axis_tlast};
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      o.data = bus.m_axis_tdata;
      o.user = bus.m_axis_tuser;
      o.last = bus.m_axis_tlast;
      o.cyc  = cyc;
      capq.push_back(o);
    end
    xfer_src  = -1;
    xfer_last = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (bus.s_axis_tvalid[i] && rdy_s[i]) begin
        xfer_src  = i;
        xfer_last = bus.s_axis_tlast[i];
      end
    end
    @(posedge clk);
    #1;
    if (xfer_src >= 0 && !rst) void'(srcq[xfer_src].pop_front());
    cyc++;
    drive();
  endtask

  task automatic run_caps(int n, int budget, string tag);
    int j;
    j = 0;
    while (capq.size() < n && j < budget) begin
      cycle();
      j++;
    end
    chk({tag, " beats_within_budget"}, DW'(capq.size() >= n), DW'(1));
  endtask

  task automatic check_gaps(string tag);
    for (int i = 1; i < capq.size(); i++)
      chk($sformatf("%s gap%0d", tag, i), DW'(capq[i].cyc - capq[i-1].cyc), DW'(capq[i-1].last ? 2 : 1));
  endtask

  task automatic compare_stream(string tag);
    chk({tag, " beat_count"}, DW'(capq.size()), DW'(expq.size()));
    for (int i = 0; i < expq.size() && i < capq.size(); i++) begin
      chk($sformatf("%s beat%0d data", tag, i), capq[i].data, expq[i].data);
      chk($sformatf("%s beat%0d tuser", tag, i), DW'(capq[i].user), DW'(expq[i].user));
      chk($sformatf("%s beat%0d tlast", tag, i), DW'(capq[i].last), DW'(expq[i].last));
    end
    capq.delete();
    expq.delete();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Packet-level model: every source with packets left requests at each
  // arbitration point, so packets leave in round-robin source order.
  task automatic build_random();
    int last, s, n, left;
    beat_t x;
    logic [DW-1:0] d;
    left = 0;
    for (int si = 0; si < NF; si++) begin
      for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
        n = $urandom_range(1, 4);
        plen[si].push_back(n);
        left++;
        for (int b = 0; b < n; b++) begin
          for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
          pdat[si].push_back(d);
          x.data  = d;
          x.last  = (b == n-1);
          x.first = (b == 0);
          srcq[si].push_back(x);
        end
      end
    end
    last = NF - 1;
    while (left > 0) begin
      s = last;
      for (int j = 1; j <= NF; j++) begin
        s = (last + j) % NF;
        if (plen[s].size() > 0) break;
      end
      n = plen[s].pop_front();
      for (int b = 0; b < n; b++) exp_beat(pdat[s].pop_front(), s, b == n-1);
      last = s;
      left--;
    end
  endtask

  initial begin
    drive();
    // Asynchronous reset asserted between clock edges.
    #7 rst = 1'b1;
    #1;
    chk("async_rst m_tvalid", DW'(bus.m_axis_tvalid), '0);
    chk("async_rst s_tready", DW'(bus.s_axis_tready), '0);
    chk("async_rst m_tdata", bus.m_axis_tdata, '0);
    chk("async_rst m_tuser", DW'(bus.m_axis_tuser), '0);
    chk("async_rst m_tlast", DW'(bus.m_axis_tlast), '0);
    cycle();
    cycle();
    rst = 1'b0;

    // Source 2, three beats 0xA1..0xA3.
    for (int b = 0; b < 3; b++) begin
      beat_t x;
      x.data = DW'(8'hA1 + b);
      x.last = (b == 2);
      x.first = (b == 0);
      srcq[2].push_back(x);
      exp_beat(DW'(8'hA1 + b), 2, b == 2);
    end
    drive();
    cycle();
    chk("t1 ready_before_grant", DW'(rdy_s[2]), '0);
    cycle();
    chk("t1 ready_after_grant", DW'(rdy_s[2]), DW'(1));
    g = cyc - 1;
    run_caps(3, 30, "t1");
    if (capq.size() > 0) chk("t1 data_latency", DW'(capq[0].cyc - g), DW'(1));
    compare_stream("t1");

    // Rotation among sources 0, 1 and 5.
    reset_pulse();
    for (int p = 0; p < 2; p++) begin
      load_pkt(0, p, 2);
      load_pkt(1, p, 2);
      load_pkt(5, p, 2);
      exp_pkt(0, p, 2);
      exp_pkt(1, p, 2);
      exp_pkt(5, p, 2);
    end
    drive();
    run_caps(12, 200, "rot");
    check_gaps("rot");
    compare_stream("rot");

    // Backpressure on an 8-beat packet from source 3.
    rmode = 1;
    nstall = 0;
    load_pkt(3, 0, 8);
    exp_pkt(3, 0, 8);
    drive();
    run_caps(8, 100, "bp");
    chk("bp stalls_seen", DW'(nstall > 0), DW'(1));
    compare_stream("bp");
    rmode = 0;
    drive();

    // Lock hold: source 4 pauses mid-packet while source 0 requests.
    load_pkt(4, 0, 4);
    drive();
    k = 0;
    while (srcq[4].size() > 2 && k < 20) begin
      cycle();
      k++;
    end
    chk("lock two_beats_accepted", DW'(srcq[4].size()), DW'(2));
    hold[4] = 1'b1;
    load_pkt(0, 0, 2);
    drive();
    saw0 = 1'b0;
    repeat (5) begin
      cycle();
      if (rdy_s[0]) saw0 = 1'b1;
    end
    hold[4] = 1'b0;
    drive();
    k = 0;
    xfer_src = -1;
    while (!(xfer_src == 4 && xfer_last) && k < 20) begin
      cycle();
      if (rdy_s[0]) saw0 = 1'b1;
      k++;
    end
    chk("lock tlast_transfer", DW'(xfer_src == 4 && xfer_last), DW'(1));
    chk("lock src0_no_ready", DW'(saw0), '0);
    tl = cyc - 1;
    k = 0;
    while (k < 10) begin
      cycle();
      k++;
      if (rdy_s[0]) break;
    end
    chk("lock regrant_delay", DW'(cyc - 1 - tl), DW'(2));
    exp_pkt(4, 0, 4);
    exp_pkt(0, 0, 2);
    run_caps(6, 40, "lock");
    compare_stream("lock");

    // Single-beat packets from all sources.
    reset_pulse();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NF; s++) begin
        load_pkt(s, p, 1);
        exp_pkt(s, p, 1);
      end
    drive();
    run_caps(12, 200, "single");
    check_gaps("single");
    compare_stream("single");

    // Reset during beat 2 of a 4-beat packet from source 1.
    load_pkt(1, 0, 4);
    drive();
    k = 0;
    while (srcq[1].size() > 2 && k < 20) begin
      cycle();
      k++;
    end
    chk("rstmid two_beats_accepted", DW'(srcq[1].size()), DW'(2));
    #1 rst = 1'b1;
    #1;
    chk("rstmid m_tvalid_cleared", DW'(bus.m_axis_tvalid), '0);
    chk("rstmid m_tdata_cleared", bus.m_axis_tdata, '0);
    load_pkt(0, 0, 2);
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    exp_beat(mk(1, 0, 0), 1, 1'b0);
    exp_pkt(0, 0, 2);
    exp_beat(mk(1, 0, 2), 1, 1'b0);
    exp_beat(mk(1, 0, 3), 1, 1'b1);
    run_caps(5, 60, "rstmid");
    compare_stream("rstmid");

    // Randomized packets, source pauses and downstream backpressure.
    reset_pulse();
    rand_hold = 1'b1;
    rmode = 2;
    build_random();
    drive();
    run_caps(expq.size(), 3000, "rand");
    compare_stream("rand");
    rand_hold = 1'b0;
    rmode = 0;
    hold = '0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/axis_fan_in.md
# axis_fan_in

Round-robin, packet-locked AXI-stream arbiter that merges NUM_FANIN source streams into one master stream. Grant is held for a whole packet (through tlast), then priority rotates to the next source. The master side carries a one-hot tuser that identifies the source, in the same format used to steer a downstream fan-out, so return traffic can be routed back to the originating channel. Output is a single register stage.

## Interface
- NUM_FANIN, 6: number of source streams (≥2).
- DATA_WIDTH, 256: beat width in bits.
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- s_axis_tvalid  input  NUM_FANIN  per-source valid.
- s_axis_tready  output  NUM_FANIN  per-source ready; at most one bit high.
- s_axis_tdata  input  NUM_FANIN*DATA_WIDTH  packed data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast  input  NUM_FANIN  per-source end of packet.
- m_axis_tvalid  output  1  master valid.
- m_axis_tready  input  1  master ready.
- m_axis_tdata  output  DATA_WIDTH  master data.
- m_axis_tuser  output  NUM_FANIN  one-hot source of the current beat.
- m_axis_tlast  output  1  master end of packet.

## Operation
- State machine, two states:
  - IDLE: all s_axis_tready = 0.
    - If any s_axis_tvalid bit is high, the arbiter selects the first requesting index, searching upward (with wrap) from last_grant+1.
    - The selection is registered into the one-hot grant register, and the state moves to LOCKED on the next cycle.
    - If no request is present, the block stays in IDLE.
  - LOCKED: s_axis_tready[g] = ~m_axis_tvalid | m_axis_tready for the granted index g. All other ready bits are 0.
    - A source beat transfers when s_axis_tvalid[g] & s_axis_tready[g].
    - On a transfer with s_axis_tlast[g] = 1, the state returns to IDLE next cycle and last_grant is set to g.
- Output register:
  - On a source transfer, it loads tdata, tlast and tuser = grant, and sets m_axis_tvalid = 1.
  - Otherwise, if m_axis_tready = 1, it clears m_axis_tvalid.
  - Otherwise it holds. tdata, tuser and tlast stay stable while m_axis_tvalid & ~m_axis_tready.
- m_axis_tdata, m_axis_tuser and m_axis_tlast are zeroed whenever m_axis_tvalid is 0.
- The granted source may drop tvalid mid-packet. The grant is held indefinitely; there is no timeout and no preemption.
- Requests from non-granted sources are ignored until the arbiter returns to IDLE.
- Single-beat packets (tlast on the first beat) are legal and release the grant immediately.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - grant 0.
  - last_grant = NUM_FANIN-1, so source 0 has first priority.
- Reset mid-packet: the packet is aborted with no tlast emitted. The output register is cleared and arbitration restarts from source 0.

## Timing
- Arbitration: a request seen in IDLE at edge t gives s_axis_tready for that source from cycle t+1.
- Data latency: a beat accepted at edge t is presented on m_axis at cycle t+1.
- Throughput: 1 beat/cycle within a packet when m_axis_tready = 1.
- Inter-packet gap: exactly one IDLE cycle between a tlast transfer and the next grant. Back-to-back packets therefore occupy N+1 cycles per N beats.
- Backpressure: when m_axis_tready = 0 with m_axis_tvalid = 1, s_axis_tready[g] drops combinationally in the same cycle. No beat is lost or duplicated.
- No combinational path from s_axis_tvalid to s_axis_tready. The only combinational path into s_axis_tready is from m_axis_tready.

## Test plan
- Reset check: assert rst asynchronously mid-cycle. All outputs are 0 immediately. After release with source 2 requesting a 3-beat packet (D=0xA1..0xA3), m_axis shows 0xA1, 0xA2, 0xA3 with tuser = 6'b000100 and tlast only on 0xA3.
- Rotation: sources 0, 1 and 5 hold 2-beat packets simultaneously. Output order is 0, 1, 5, 0, ... Each packet is contiguous, and there is one idle cycle between packets.
- Backpressure: 8-beat packet from source 3 with m_axis_tready toggling 1,0,0,1,... All 8 beats arrive in order. Data is stable during stalls, and s_axis_tready[3] = 0 in every stall cycle.
- Lock hold: source 4 drops tvalid for 5 cycles mid-packet while source 0 requests. Source 0 gets no ready until source 4 sends tlast. Source 0 is granted 2 cycles after that tlast transfer.
- Single-beat packets: all 6 sources send 1-beat packets continuously. The output cycles tuser through 000001, 000010, ..., 100000 with tlast = 1 on every beat. Output rate is 1 beat per 2 cycles.
- Reset mid-packet: assert rst during beat 2 of a 4-beat packet from source 1. After release, source 1 (still valid) is re-arbitrated only after source 0 if source 0 is requesting. No stale m_axis_tvalid appears.
